// File: rtl/msg_buf_mem.sv
// msg_buf_mem: Wishbone-pipelined slave holding an NCHARS-character message
// buffer, presented as a printable frame "0","x",char[0..NCHARS-1],"\n","\r".
//
// Ports:
//   i_clk, i_reset_n      clock, async active-low reset
//   i_cyc, i_stb, i_we    bus cycle / strobe / write enable
//   i_addr[AW], i_data[W] frame address, write character
//   i_clear               pulse: start the NCHARS-cycle buffer clear sequence
//   o_stall               request not accepted (high only while clearing)
//   o_ack, o_data[W]      one ack per accepted request, LAT cycles later
//   o_busy                clear sequence in progress
//
// Optional build macro HEX_ENCODE_EN: data-region reads return the ASCII hex
// digit of the stored character's low nibble instead of the raw value.
module msg_buf_mem #(
  parameter int NCHARS = 8,
  parameter int W      = 8,
  parameter int AW     = 5,
  parameter int LAT    = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cyc,
  input  logic          i_stb,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_data,
  input  logic          i_clear,
  output logic          o_stall,
  output logic          o_ack,
  output logic [W-1:0]  o_data,
  output logic          o_busy
);

  localparam int IW = (NCHARS > 1) ? $clog2(NCHARS) : 1;

  if (NCHARS < 1 || W < 8 || LAT < 1 || LAT > 4 || (NCHARS + 4) > (2 ** AW)) begin : g_bad_cfg
    $error("msg_buf_mem: illegal parameters (need NCHARS>=1, W>=8, 1<=LAT<=4, NCHARS+4<=2**AW)");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                   state;
  logic [IW-1:0]            idx;
  logic                     busy;
  logic [NCHARS-1:0][W-1:0] mem;

  logic                     accept;
  logic                     in_data;
  logic [IW-1:0]            cidx;
  logic [31:0]              a;
  logic [W-1:0]             rd_val;
  logic                     vld_in;
  logic [W-1:0]             dat_in;
  logic [LAT:1]             vld_pipe;
  logic [LAT:1][W-1:0]      dat_pipe;

  assign o_busy  = busy;
  assign o_stall = busy;
  assign accept  = i_cyc & i_stb & ~busy;

  // Frame decode; read data is taken from storage as it stands before this
  // edge, so a write lands in time for a read in the following cycle.
  always_comb begin
    a       = 32'(i_addr);
    in_data = (a >= 32'd2) && (a < 32'(NCHARS + 2));
    cidx    = in_data ? IW'(a - 32'd2) : '0;
    rd_val  = '0;
    if (a == 32'd0)                       rd_val = W'(8'h30);
    else if (a == 32'd1)                  rd_val = W'(8'h78);
    else if (in_data) begin
`ifdef HEX_ENCODE_EN
      if (mem[cidx][3:0] < 4'd10) rd_val = W'(8'h30 + {4'd0, mem[cidx][3:0]});
      else                        rd_val = W'(8'h57 + {4'd0, mem[cidx][3:0]});
`else
      rd_val = mem[cidx];
`endif
    end
    else if (a == 32'(NCHARS + 2))        rd_val = W'(8'h0a);
    else if (a == 32'(NCHARS + 3))        rd_val = W'(8'h0d);
  end

  // Writes carry zero data on their ack; idle stages carry zero so o_data
  // is 0 whenever o_ack is low.
  assign vld_in = accept;
  assign dat_in = (accept && !i_we) ? rd_val : '0;

  // Ack pipeline: dropping i_cyc kills everything in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (!i_cyc) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= vld_in;
      dat_pipe[1] <= dat_in;
      for (int s = 2; s <= LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign o_ack  = vld_pipe[LAT];
  assign o_data = dat_pipe[LAT];

  // Storage and clear FSM. Requests are stalled in CLEAR, so a bus write and
  // a clear write never target storage in the same cycle; a write accepted
  // alongside i_clear commits now and is wiped later by the sweep.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mem   <= '0;
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      if (accept && i_we && in_data) mem[cidx] <= i_data;
      case (state)
        IDLE: begin
          if (i_clear) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          mem[idx] <= '0;
          if (idx == IW'(NCHARS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
